// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two-read / one-write register file with byte-lane write
// strobes and a pending-write scoreboard. Register 0 reads as zero and is
// never pending. All state changes happen on the falling edge of clk, so
// decode-stage reads in the second half of a cycle see the writeback
// presented in the first half.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the in-flight write
// data (byte-merged with the stored word) to a read port whose address
// matches w_addr before the falling edge. When undefined, reads return the
// array contents only and no bypass muxes are built.
module regfile_2r1w #(
    parameter int              WIDTH     = 32,
    parameter int              DEPTH     = 32,
    parameter int              AW        = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        ra_addr,
    output logic [WIDTH-1:0]     ra_data,
    output logic                 ra_pend,
    input  logic [AW-1:0]        rb_addr,
    output logic [WIDTH-1:0]     rb_data,
    output logic                 rb_pend,
    input  logic                 w_en,
    input  logic [AW-1:0]        w_addr,
    input  logic [WIDTH-1:0]     w_data,
    input  logic [WIDTH/8-1:0]   w_be,
    input  logic                 p_set,
    input  logic [AW-1:0]        p_addr,
    output logic                 p_busy
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [WIDTH-1:0] be_mask;
    logic [WIDTH-1:0] w_merged;
    logic             w_live;

    // A write only has an architectural effect on registers 1..DEPTH-1.
    assign w_live = w_en && (w_addr != '0);

    // Expand byte strobes to a bit mask and merge new lanes over the stored word.
    always_comb begin
        be_mask = '0;
        for (int i = 0; i < NB; i++) begin
            be_mask[8*i +: 8] = {8{w_be[i]}};
        end
        w_merged = (mem[w_addr] & ~be_mask) | (w_data & be_mask);
    end

    // Register array: async reset to RESET_VAL, falling-edge byte-lane write.
    // Entry 0 is held at zero and never written; an all-zero strobe rewrites
    // the old value, which is harmless.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == 0) ? '0 : RESET_VAL;
            end
        end else if (w_live) begin
            mem[w_addr] <= w_merged;
        end
    end

    // Scoreboard next state: a write clears its target, p_set then sets its
    // target, so a same-edge set on the same address wins. Bit 0 never pends.
    always_comb begin
        pend_nxt = pend;
        if (w_en) begin
            pend_nxt[w_addr] = 1'b0;
        end
        if (p_set) begin
            pend_nxt[p_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register, updated on the falling edge like the array.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign p_busy = |pend;

`ifdef REGFILE_BYPASS_EN
    logic ra_hit;
    logic rb_hit;

    assign ra_hit = w_live && (ra_addr == w_addr);
    assign rb_hit = w_live && (rb_addr == w_addr);

    // Read port A with forwarding of the in-flight write; a forwarded operand
    // is no longer pending unless a new producer claims it this same cycle.
    always_comb begin
        ra_data = '0;
        ra_pend = pend[ra_addr];
        if (ra_addr != '0) begin
            ra_data = mem[ra_addr];
        end
        if (ra_hit) begin
            ra_data = w_merged;
            ra_pend = p_set && (p_addr == ra_addr);
        end
    end

    // Read port B, same forwarding rules as port A.
    always_comb begin
        rb_data = '0;
        rb_pend = pend[rb_addr];
        if (rb_addr != '0) begin
            rb_data = mem[rb_addr];
        end
        if (rb_hit) begin
            rb_data = w_merged;
            rb_pend = p_set && (p_addr == rb_addr);
        end
    end
`else
    // Read port A: plain combinational array read, zero for register 0.
    always_comb begin
        ra_data = '0;
        ra_pend = pend[ra_addr];
        if (ra_addr != '0) begin
            ra_data = mem[ra_addr];
        end
    end

    // Read port B: plain combinational array read, zero for register 0.
    always_comb begin
        rb_data = '0;
        rb_pend = pend[rb_addr];
        if (rb_addr != '0) begin
            rb_data = mem[rb_addr];
        end
    end
`endif

endmodule
